// File: rtl/tpu_pkg.sv
// Shared definitions for the tpu matrix-multiply engine: sizes, FSM encoding
// and element helpers.
package tpu_pkg;

    localparam int ARRAY_SIZE = 16;
    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 12;
    localparam int WORD_WIDTH = ARRAY_SIZE * DATA_WIDTH;
    localparam int IDX_WIDTH  = $clog2(ARRAY_SIZE);
    localparam int ACC_WIDTH  = 2 * DATA_WIDTH + IDX_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -(ACC_WIDTH'(2 ** (DATA_WIDTH - 1)));

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_B   = 3'd1,
        ST_STREAM_A = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    function automatic logic [ADDR_WIDTH-1:0] clamp_dim(input logic [ADDR_WIDTH-1:0] d);
        if (d > ADDR_WIDTH'(ARRAY_SIZE)) begin
            return ADDR_WIDTH'(ARRAY_SIZE);
        end else begin
            return d;
        end
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sat_elem(input logic signed [ACC_WIDTH-1:0] acc);
        if (acc > SAT_MAX) begin
            return SAT_MAX[DATA_WIDTH-1:0];
        end else if (acc < SAT_MIN) begin
            return SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            return acc[DATA_WIDTH-1:0];
        end
    endfunction

endpackage

// File: rtl/tpu_row_mac.sv
// Combinational row x matrix product with A-lane (k) and output-lane (n) masking.
// Define TPU_SAT_EN to saturate each element instead of wrapping to 16 bits.
module tpu_row_mac
    import tpu_pkg::*;
(
    input  logic [WORD_WIDTH-1:0]                 a_row,
    input  logic [ARRAY_SIZE-1:0][WORD_WIDTH-1:0] b_rows,
    input  logic [ADDR_WIDTH-1:0]                 k_dim,
    input  logic [ADDR_WIDTH-1:0]                 n_dim,
    output logic [WORD_WIDTH-1:0]                 p_row
);

    logic signed [ACC_WIDTH-1:0]    acc_s [ARRAY_SIZE];
    logic signed [DATA_WIDTH-1:0]   a_el_s;
    logic signed [DATA_WIDTH-1:0]   b_el_s;
    logic signed [2*DATA_WIDTH-1:0] prod_s;

    // Dot product of the masked A row with each B column, then lane masking.
    always_comb begin
        p_row  = '0;
        a_el_s = '0;
        b_el_s = '0;
        prod_s = '0;
        for (int j = 0; j < ARRAY_SIZE; j++) begin
            acc_s[j] = '0;
            for (int r = 0; r < ARRAY_SIZE; r++) begin
                if (ADDR_WIDTH'(r) < k_dim) begin
                    a_el_s = a_row[r*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    a_el_s = '0;
                end
                b_el_s   = b_rows[r][j*DATA_WIDTH +: DATA_WIDTH];
                prod_s   = a_el_s * b_el_s;
                acc_s[j] = acc_s[j] + ACC_WIDTH'(prod_s);
            end
            if (ADDR_WIDTH'(j) < n_dim) begin
`ifdef TPU_SAT_EN
                p_row[j*DATA_WIDTH +: DATA_WIDTH] = sat_elem(acc_s[j]);
`else
                p_row[j*DATA_WIDTH +: DATA_WIDTH] = acc_s[j][DATA_WIDTH-1:0];
`endif
            end else begin
                p_row[j*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
        end
    end

endmodule

// File: rtl/tpu.sv
// Matrix-multiply engine top: FSM, address counters, B row buffer, P output register.
// Optional TPU_SAT_EN selects saturating instead of wrapping output elements.
module tpu
    import tpu_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    output logic                  valid_o,
    input  logic [ADDR_WIDTH-1:0] m_i,
    input  logic [ADDR_WIDTH-1:0] k_i,
    input  logic [ADDR_WIDTH-1:0] n_i,
    input  logic [ADDR_WIDTH-1:0] base_addra_i,
    input  logic [ADDR_WIDTH-1:0] base_addrb_i,
    input  logic [ADDR_WIDTH-1:0] base_addrp_i,
    output logic                  ena_o,
    output logic                  wea_o,
    output logic [ADDR_WIDTH-1:0] addra_o,
    input  logic [WORD_WIDTH-1:0] worda_i,
    output logic                  enb_o,
    output logic                  web_o,
    output logic [ADDR_WIDTH-1:0] addrb_o,
    input  logic [WORD_WIDTH-1:0] wordb_i,
    output logic                  enp_o,
    output logic                  wep_o,
    output logic [ADDR_WIDTH-1:0] addrp_o,
    output logic [WORD_WIDTH-1:0] wordp_o
);

    state_t                state_r, state_s;
    logic [ADDR_WIDTH-1:0] cnt_r, cnt_s;
    logic [ADDR_WIDTH-1:0] m_r, k_r, n_r, base_a_r, base_b_r, base_p_r;
    logic                  ena_r, ena_s, enb_r, enb_s, valid_r, valid_s;
    logic [ADDR_WIDTH-1:0] addra_r, addra_s, addrb_r, addrb_s;
    logic                  b_cap_r, a_cap_r, enp_r;
    logic [IDX_WIDTH-1:0]  b_idx_r;
    logic [ADDR_WIDTH-1:0] a_idx_r, addrp_r;
    logic [WORD_WIDTH-1:0] wordp_r, mac_row_s;
    logic [ARRAY_SIZE-1:0][WORD_WIDTH-1:0] b_buf_r;
    logic                  accept_s, zero_dim_s;

    assign accept_s   = start_i && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign zero_dim_s = (m_i == '0) || (k_i == '0) || (n_i == '0);

    // Next-state and next read-port values; outputs are registered from these.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        valid_s = valid_r;
        ena_s   = 1'b0;
        addra_s = '0;
        enb_s   = 1'b0;
        addrb_s = '0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    cnt_s = '0;
                    if (zero_dim_s) begin
                        state_s = ST_DONE;
                        valid_s = 1'b1;
                    end else begin
                        state_s = ST_LOAD_B;
                        valid_s = 1'b0;
                        enb_s   = 1'b1;
                        addrb_s = base_addrb_i;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_LOAD_B: begin
                if (cnt_r == k_r - ADDR_WIDTH'(1)) begin
                    state_s = ST_STREAM_A;
                    cnt_s   = '0;
                    ena_s   = 1'b1;
                    addra_s = base_a_r;
                end else begin
                    cnt_s   = cnt_r + ADDR_WIDTH'(1);
                    enb_s   = 1'b1;
                    addrb_s = base_b_r + cnt_r + ADDR_WIDTH'(1);
                end
            end
            ST_STREAM_A: begin
                if (cnt_r == m_r - ADDR_WIDTH'(1)) begin
                    state_s = ST_DRAIN;
                    cnt_s   = '0;
                end else begin
                    cnt_s   = cnt_r + ADDR_WIDTH'(1);
                    ena_s   = 1'b1;
                    addra_s = base_a_r + cnt_r + ADDR_WIDTH'(1);
                end
            end
            ST_DRAIN: begin
                // The final write is on the port now and no A word is still in flight.
                if (enp_r && !a_cap_r) begin
                    state_s = ST_DONE;
                    valid_s = 1'b1;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
                valid_s = 1'b0;
            end
        endcase
    end

    // Control state, latched operation parameters and registered read ports.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            valid_r  <= 1'b0;
            ena_r    <= 1'b0;
            addra_r  <= '0;
            enb_r    <= 1'b0;
            addrb_r  <= '0;
            m_r      <= '0;
            k_r      <= '0;
            n_r      <= '0;
            base_a_r <= '0;
            base_b_r <= '0;
            base_p_r <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            valid_r <= valid_s;
            ena_r   <= ena_s;
            addra_r <= addra_s;
            enb_r   <= enb_s;
            addrb_r <= addrb_s;
            if (accept_s) begin
                m_r      <= clamp_dim(m_i);
                k_r      <= clamp_dim(k_i);
                n_r      <= clamp_dim(n_i);
                base_a_r <= base_addra_i;
                base_b_r <= base_addrb_i;
                base_p_r <= base_addrp_i;
            end
        end
    end

    // Read-return tracking (data lands one cycle after the read) and P write register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            b_cap_r <= 1'b0;
            b_idx_r <= '0;
            a_cap_r <= 1'b0;
            a_idx_r <= '0;
            enp_r   <= 1'b0;
            addrp_r <= '0;
            wordp_r <= '0;
        end else begin
            b_cap_r <= enb_r;
            b_idx_r <= cnt_r[IDX_WIDTH-1:0];
            a_cap_r <= ena_r;
            a_idx_r <= cnt_r;
            if (a_cap_r) begin
                enp_r   <= 1'b1;
                addrp_r <= base_p_r + a_idx_r;
                wordp_r <= mac_row_s;
            end else begin
                enp_r   <= 1'b0;
                addrp_r <= '0;
                wordp_r <= '0;
            end
        end
    end

    // B row buffer; contents are don't-care after reset.
    always_ff @(posedge clk_i) begin
        if (b_cap_r) begin
            b_buf_r[b_idx_r] <= wordb_i;
        end
    end

    tpu_row_mac u_row_mac (
        .a_row  (worda_i),
        .b_rows (b_buf_r),
        .k_dim  (k_r),
        .n_dim  (n_r),
        .p_row  (mac_row_s)
    );

    assign valid_o = valid_r;
    assign ena_o   = ena_r;
    assign wea_o   = 1'b0;
    assign addra_o = addra_r;
    assign enb_o   = enb_r;
    assign web_o   = 1'b0;
    assign addrb_o = addrb_r;
    assign enp_o   = enp_r;
    assign wep_o   = enp_r;
    assign addrp_o = addrp_r;
    assign wordp_o = wordp_r;

endmodule

// File: tb/tb_tpu.sv
// Directed self-checking bench for tpu: RAM models, expected-write scoreboard,
// port timing and reset checks.
module tb_tpu;
    import tpu_pkg::*;

    typedef logic [WORD_WIDTH-1:0] word_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef struct {
        addr_t addr;
        word_t word;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  start = 1'b0;
    logic  valid;
    addr_t m_in = '0, k_in = '0, n_in = '0, ba_in = '0, bb_in = '0, bp_in = '0;
    logic  ena, wea, enb, web, enp, wep;
    addr_t addra, addrb, addrp;
    word_t worda, wordb, wordp;

    word_t ram_a [0:4095];
    word_t ram_b [0:4095];
    word_t ram_p [0:4095];

    exp_t  sb [$];
    int    rd_a_cyc [$], rd_b_cyc [$];
    addr_t rd_a_addr [$], rd_b_addr [$];
    int    vectors = 0;
    int    miscompares = 0;
    int    cyc, nwr;
    logic  found;

    tpu dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .valid_o(valid),
        .m_i(m_in), .k_i(k_in), .n_i(n_in),
        .base_addra_i(ba_in), .base_addrb_i(bb_in), .base_addrp_i(bp_in),
        .ena_o(ena), .wea_o(wea), .addra_o(addra), .worda_i(worda),
        .enb_o(enb), .web_o(web), .addrb_o(addrb), .wordb_i(wordb),
        .enp_o(enp), .wep_o(wep), .addrp_o(addrp), .wordp_o(wordp)
    );

    always #5 clk = ~clk;

    // Synchronous RAM read ports; junk on the bus when not enabled.
    always @(posedge clk) begin
        worda <= ena ? ram_a[addra] : {8{$urandom()}};
        wordb <= enb ? ram_b[addrb] : {8{$urandom()}};
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic word_t model_row(input int ai, input int k, input int n, input int bb);
        word_t w;
        longint acc;
        logic signed [15:0] av, bv;
        w = '0;
        for (int j = 0; j < n && j < 16; j++) begin
            acc = 0;
            for (int r = 0; r < k && r < 16; r++) begin
                av  = ram_a[ai % 4096][r*16 +: 16];
                bv  = ram_b[(bb + r) % 4096][j*16 +: 16];
                acc = acc + longint'(av) * longint'(bv);
            end
`ifdef TPU_SAT_EN
            if (acc > 32767) acc = 32767;
            else if (acc < -32768) acc = -32768;
`endif
            w[j*16 +: 16] = acc[15:0];
        end
        return w;
    endfunction

    task automatic push_exp(input int m, input int k, input int n, input int ba, input int bb, input int bp);
        exp_t e;
        for (int i = 0; i < m; i++) begin
            e.addr = addr_t'(bp + i);
            e.word = model_row(ba + i, k, n, bb);
            sb.push_back(e);
        end
    endtask

    task automatic start_op(input int m, input int k, input int n, input int ba, input int bb, input int bp);
        @(negedge clk);
        m_in = addr_t'(m); k_in = addr_t'(k); n_in = addr_t'(n);
        ba_in = addr_t'(ba); bb_in = addr_t'(bb); bp_in = addr_t'(bp);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Inputs are latched at start; scramble them while busy.
        m_in = addr_t'($urandom); k_in = addr_t'($urandom); n_in = addr_t'($urandom);
        ba_in = addr_t'($urandom); bb_in = addr_t'($urandom); bp_in = addr_t'($urandom);
    endtask

    // Samples every negedge from cycle 1 after start until valid_o or budget.
    task automatic run_op(input int budget, input bit poke, output int cyc_o, output int nwr_o);
        exp_t e;
        int viol;
        int c;
        viol = 0; nwr_o = 0;
        rd_a_cyc.delete(); rd_b_cyc.delete(); rd_a_addr.delete(); rd_b_addr.delete();
        for (c = 1; c <= budget; c++) begin
            if (enb) begin rd_b_cyc.push_back(c); rd_b_addr.push_back(addrb); end
            if (ena) begin rd_a_cyc.push_back(c); rd_a_addr.push_back(addra); end
            if (wea || web) viol++;
            if (!ena && addra != '0) viol++;
            if (!enb && addrb != '0) viol++;
            if (enp) begin
                if (!wep) viol++;
                if (sb.size() == 0) begin
                    chk("unexpected P write", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk("P addr", addrp, e.addr);
                    chk("P word", wordp, e.word);
                end
                ram_p[addrp] = wordp;
                nwr_o++;
            end else if (addrp != '0 || wordp != '0 || wep) begin
                viol++;
            end
            if (valid) break;
            if (poke && c == 1) begin start = 1'b1; m_in = 12'd16; end
            if (poke && c == 3) start = 1'b0;
            @(negedge clk);
        end
        cyc_o = c;
        chk("valid_o within budget", valid, 1'b1);
        chk("idle port hygiene", viol, 0);
        chk("scoreboard drained", sb.size(), 0);
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) begin
            ram_a[a] = {8{$urandom()}};
            ram_b[a] = {8{$urandom()}};
            ram_p[a] = '0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset ctrl outs", {valid, ena, enb, enp, wep, wea, web}, 7'd0);
        chk("reset addr outs", {addra, addrb, addrp}, 36'd0);
        chk("reset wordp", wordp, 256'd0);
        rst_n = 1'b1;

        // 10x10x10: A[i][j]=(i+1)(j+1), B=2I; junk lanes beyond 10 exercise masking
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 10; j++) begin
                ram_a[12'h000 + i][j*16 +: 16] = 16'((i + 1) * (j + 1));
                ram_b[12'h100 + i][j*16 +: 16] = (i == j) ? 16'd2 : 16'd0;
            end
        end
        push_exp(10, 10, 10, 12'h000, 12'h100, 12'h200);
        start_op(10, 10, 10, 12'h000, 12'h100, 12'h200);
        run_op(60, 1'b0, cyc, nwr);
        chk("10x10 latency", cyc, 23);
        chk("10x10 writes", nwr, 10);
        for (int j = 0; j < 10; j++) chk("10x10 row0 lane", ram_p[12'h200][j*16 +: 16], 16'(2 * (j + 1)));
        chk("10x10 row9 lane9", ram_p[12'h209][9*16 +: 16], 16'd200);
        chk("10x10 row3 hi lanes", ram_p[12'h203][255:160], 96'd0);

        // 1x1x1: 3 * -4 = -12
        ram_a[12'h010][15:0] = 16'd3;
        ram_b[12'h020][15:0] = 16'hFFFC;
        sb.push_back('{addr: 12'h030, word: 256'hFFF4});
        start_op(1, 1, 1, 12'h010, 12'h020, 12'h030);
        run_op(30, 1'b0, cyc, nwr);
        chk("1x1 writes", nwr, 1);
        chk("1x1 latency", cyc, 5);
        chk("1x1 reads", {rd_a_addr.size(), rd_b_addr.size()}, {32'd1, 32'd1});

        // Overflow: 4 * 300 * 300 = 360000
        for (int r = 0; r < 6; r++) ram_b[12'h050 + r] = {16{16'd300}};
        ram_a[12'h040] = {16{16'd300}};
        push_exp(1, 4, 16, 12'h040, 12'h050, 12'h060);
        start_op(1, 4, 16, 12'h040, 12'h050, 12'h060);
        run_op(30, 1'b0, cyc, nwr);
        chk("overflow B reads", rd_b_addr.size(), 4);
`ifdef TPU_SAT_EN
        chk("overflow lanes", ram_p[12'h060], {16{16'h7FFF}});
`else
        chk("overflow lanes", ram_p[12'h060], {16{16'h7E40}});
`endif

        // Non-square m=3,k=5,n=2 with a start/dimension poke while busy
        push_exp(3, 5, 2, 12'h300, 12'h400, 12'h500);
        start_op(3, 5, 2, 12'h300, 12'h400, 12'h500);
        run_op(40, 1'b1, cyc, nwr);
        chk("nsq B reads", rd_b_addr.size(), 5);
        chk("nsq A reads", rd_a_addr.size(), 3);
        for (int r = 0; r < 5 && r < rd_b_addr.size(); r++)
            chk("nsq B read", {rd_b_cyc[r], rd_b_addr[r]}, {32'(1 + r), 12'(12'h400 + r)});
        for (int i = 0; i < 3 && i < rd_a_addr.size(); i++)
            chk("nsq A read", {rd_a_cyc[i], rd_a_addr[i]}, {32'(6 + i), 12'(12'h300 + i)});
        chk("nsq writes", nwr, 3);
        chk("nsq latency", cyc, 11);
        for (int i = 0; i < 3; i++) chk("nsq lanes 2..15", ram_p[12'h500 + i][255:32], 224'd0);

        // Zero dimension
        start_op(4, 0, 4, 12'h000, 12'h100, 12'h600);
        run_op(10, 1'b0, cyc, nwr);
        chk("k=0 latency", cyc, 1);
        chk("k=0 accesses", {rd_a_addr.size(), rd_b_addr.size(), nwr}, 96'd0);

        // Reset in the middle of STREAM_A, then a full rerun
        start_op(10, 10, 10, 12'h000, 12'h100, 12'h700);
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (ena) begin found = 1'b1; break; end
            @(negedge clk);
        end
        chk("reached STREAM_A", found, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid-op reset ctrl outs", {valid, ena, enb, enp, wep}, 5'd0);
        chk("mid-op reset addr outs", {addra, addrb, addrp}, 36'd0);
        chk("mid-op reset wordp", wordp, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push_exp(10, 10, 10, 12'h000, 12'h100, 12'h800);
        start_op(10, 10, 10, 12'h000, 12'h100, 12'h800);
        run_op(60, 1'b0, cyc, nwr);
        chk("post-reset latency", cyc, 23);
        chk("post-reset writes", nwr, 10);
        chk("post-reset row0 lane9", ram_p[12'h800][9*16 +: 16], 16'd20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
